// File: rtl/clk_gen_pkg.sv
// Shared clock-generation types and helpers for the divider bank.
// half_div() turns a target output frequency into a half-period divisor.
package clk_gen_pkg;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned DIV_W_DEF = 16;

  typedef logic [DIV_W_DEF-1:0] div_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_DRAIN
  } ch_state_t;

  // Half-period divisor for a 50%-duty output at freq; CLK_FREQ must split evenly.
  function automatic div_t half_div(input int unsigned freq);
    assert (freq != 0 && (CLK_FREQ % (2 * freq)) == 0);
    return div_t'(CLK_FREQ / (2 * freq) - 1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow/active divisor and IDLE/RUN/DRAIN control.
// Divisor updates take effect only on a half-period boundary or while idle.
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned      DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_we_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  ch_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [DIV_W-1:0] div_next;
  logic             tick;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= CH_IDLE;
      cnt_q     <= '0;
      shadow_q  <= DIV_RST;
      active_q  <= DIV_RST;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    // A write landing on a load edge is used directly, not one half-period late.
    div_next  = div_we_i ? div_i : shadow_q;
    tick      = (cnt_q == active_q);

    if (div_we_i) shadow_d = div_i;

    if (sync_i && en_i) begin
      state_d   = CH_RUN;
      cnt_d     = '0;
      clk_d     = 1'b0;
      fall_d    = clk_q;
      active_d  = div_next;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          cnt_d     = '0;
          clk_d     = 1'b0;
          active_d  = div_next;
          pending_d = 1'b0;
          if (en_i) state_d = CH_RUN;
        end
        CH_RUN, CH_DRAIN: begin
          if (!en_i && !clk_q) begin
            // Low phase can be abandoned at once without a glitch.
            state_d   = CH_IDLE;
            cnt_d     = '0;
            active_d  = div_next;
            pending_d = 1'b0;
          end else if (tick) begin
            clk_d     = ~clk_q;
            rise_d    = ~clk_q;
            fall_d    = clk_q;
            cnt_d     = '0;
            active_d  = div_next;
            pending_d = 1'b0;
            state_d   = en_i ? CH_RUN : CH_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = en_i ? CH_RUN : CH_DRAIN;
            if (div_we_i) pending_d = 1'b1;
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  assign clk_o     = clk_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// N-channel programmable 50%-duty clock divider bank for peripheral bit clocks.
// Channels are independent except for the shared phase-sync pulse.
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int unsigned      N_CH    = 4,
  parameter int unsigned      DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [N_CH*DIV_W-1:0] div_i,
  input  logic [N_CH-1:0]       div_we_i,
  input  logic [N_CH-1:0]       en_i,
  input  logic                  sync_i,
  output logic [N_CH-1:0]       clk_o,
  output logic [N_CH-1:0]       rise_o,
  output logic [N_CH-1:0]       fall_o,
  output logic [N_CH-1:0]       pending_o
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clk_div_ch #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
    ) u_ch (
      .clk_i    (clk_i),
      .rst      (rst),
      .div_i    (div_i[k*DIV_W +: DIV_W]),
      .div_we_i (div_we_i[k]),
      .en_i     (en_i[k]),
      .sync_i   (sync_i),
      .clk_o    (clk_o[k]),
      .rise_o   (rise_o[k]),
      .fall_o   (fall_o[k]),
      .pending_o(pending_o[k])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: event-time reference model plus directed timing checks.
// The model tracks the absolute cycle of each channel's next toggle.
module tb_clk_div_bank;

  localparam int N_CH = 4;
  localparam int DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_RST = '0;

  logic                  clk_i = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH*DIV_W-1:0] div_i = '0;
  logic [N_CH-1:0]       div_we_i = '0;
  logic [N_CH-1:0]       en_i = '0;
  logic                  sync_i = 1'b0;
  logic [N_CH-1:0]       clk_o, rise_o, fall_o, pending_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [N_CH-1:0]  m_clk = '0, m_rise = '0, m_fall = '0, m_pend = '0, m_run = '0;
  logic [DIV_W-1:0] m_sh [N_CH];
  int               m_due [N_CH];
  int               cyc = 0;
  logic [DIV_W-1:0] md, mnd;

  // per-task observation traces, index = cycles since task start
  logic [N_CH-1:0] tr_clk [64], tr_rise [64], tr_fall [64], tr_pend [64];

  clk_div_bank #(.N_CH(N_CH), .DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .clk_i    (clk_i),
    .rst      (rst),
    .div_i    (div_i),
    .div_we_i (div_we_i),
    .en_i     (en_i),
    .sync_i   (sync_i),
    .clk_o    (clk_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      for (int k = 0; k < N_CH; k++) begin
        md = div_i[k*DIV_W +: DIV_W];
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (rst) begin
          m_clk[k] = 1'b0; m_pend[k] = 1'b0; m_run[k] = 1'b0; m_sh[k] = DIV_RST;
        end else begin
          mnd = div_we_i[k] ? md : m_sh[k];
          if (div_we_i[k]) m_sh[k] = md;
          if (sync_i && en_i[k]) begin
            m_fall[k] = m_clk[k]; m_clk[k] = 1'b0; m_run[k] = 1'b1; m_pend[k] = 1'b0;
            m_due[k] = cyc + int'(mnd) + 1;
          end else if (!m_run[k]) begin
            m_pend[k] = 1'b0;
            if (en_i[k]) begin
              m_run[k] = 1'b1;
              m_due[k] = cyc + int'(mnd) + 1;
            end
          end else if (!en_i[k] && !m_clk[k]) begin
            m_run[k] = 1'b0; m_pend[k] = 1'b0;
          end else if (cyc == m_due[k]) begin
            m_clk[k] = !m_clk[k]; m_rise[k] = m_clk[k]; m_fall[k] = !m_clk[k];
            m_pend[k] = 1'b0;
            m_due[k] = cyc + int'(mnd) + 1;
            if (!en_i[k]) m_run[k] = 1'b0;
          end else if (div_we_i[k]) begin
            m_pend[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc1();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_div(input int k, input int d);
    div_i[k*DIV_W +: DIV_W] = DIV_W'(d);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL reset_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      tr_clk[i] = clk_o; tr_rise[i] = rise_o; tr_fall[i] = fall_o; tr_pend[i] = pending_o;
      if (i == 1) rst = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tr_clk[i], tr_rise[i], tr_fall[i], tr_pend[i]} !== 16'h0) begin
        errors++;
        $display("FAIL reset_state obs=%0d got=%h exp=0", i, {tr_clk[i], tr_rise[i], tr_fall[i], tr_pend[i]});
      end
    end
  endtask

  task automatic test_div0();
    for (int i = 0; i < 12; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL div0_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      tr_clk[i] = clk_o; tr_rise[i] = rise_o; tr_fall[i] = fall_o; tr_pend[i] = pending_o;
      div_we_i = '0; sync_i = 1'b0;
      if (i == 0) en_i[0] = 1'b1;
    end
    checks++;
    if (tr_clk[1][0] !== 1'b0) begin
      errors++;
      $display("FAIL div0_enable_low got=%b exp=0", tr_clk[1][0]);
    end
    for (int i = 2; i < 12; i++) begin
      checks++;
      if ({tr_clk[i][0], tr_rise[i][0], tr_fall[i][0]} !== {i % 2 == 0, i % 2 == 0, i % 2 != 0}) begin
        errors++;
        $display("FAIL div0_alternate obs=%0d got=%b%b%b exp=%b%b%b", i, tr_clk[i][0], tr_rise[i][0], tr_fall[i][0],
                 i % 2 == 0, i % 2 == 0, i % 2 != 0);
      end
    end
  endtask

  task automatic test_idle_write();
    int rl[$];
    int fl[$];
    int pend_seen;
    pend_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL idle_write_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      if (rise_o[1]) rl.push_back(i);
      if (fall_o[1]) fl.push_back(i);
      if (pending_o[1]) pend_seen++;
      div_we_i = '0; sync_i = 1'b0;
      if (i == 0) begin set_div(1, 4); div_we_i[1] = 1'b1; end
      if (i == 1) en_i[1] = 1'b1;
    end
    checks++;
    if (pend_seen != 0) begin
      errors++;
      $display("FAIL idle_write_pending got=%0d exp=0", pend_seen);
    end
    checks++;
    if (rl.size() != 3 || fl.size() != 2) begin
      errors++;
      $display("FAIL idle_write_ticks got rises=%0d falls=%0d exp rises=3 falls=2", rl.size(), fl.size());
    end else begin
      checks++;
      if (rl[0] != 7 || rl[1] != 17 || rl[2] != 27) begin
        errors++;
        $display("FAIL idle_write_period got=%0d,%0d,%0d exp=7,17,27", rl[0], rl[1], rl[2]);
      end
      checks++;
      if (fl[0] - rl[0] != 5) begin
        errors++;
        $display("FAIL idle_write_high got=%0d exp=5", fl[0] - rl[0]);
      end
    end
  endtask

  task automatic test_midphase_write();
    int r;
    r = -1;
    for (int i = 0; i < 40; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL midphase_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      tr_clk[i] = clk_o; tr_rise[i] = rise_o; tr_fall[i] = fall_o; tr_pend[i] = pending_o;
      div_we_i = '0; sync_i = 1'b0;
      if (r < 0 && rise_o[1]) r = i;
      if (r >= 0 && i == r + 1) begin set_div(1, 1); div_we_i[1] = 1'b1; end
    end
    checks++;
    if (r < 0 || r + 11 >= 40) begin
      errors++;
      $display("FAIL midphase_rise got=%0d exp=0..28", r);
    end else begin
      for (int j = r; j <= r + 6; j++) begin
        checks++;
        if (tr_pend[j][1] !== (j >= r + 2 && j <= r + 4)) begin
          errors++;
          $display("FAIL midphase_pending obs=%0d got=%b exp=%b", j - r, tr_pend[j][1], (j >= r + 2 && j <= r + 4));
        end
      end
      checks++;
      if ({tr_clk[r + 4][1], tr_fall[r + 5][1], tr_clk[r + 5][1]} !== 3'b110) begin
        errors++;
        $display("FAIL midphase_high got=%b%b%b exp=110", tr_clk[r + 4][1], tr_fall[r + 5][1], tr_clk[r + 5][1]);
      end
      checks++;
      if ({tr_rise[r + 7][1], tr_fall[r + 9][1], tr_rise[r + 11][1]} !== 3'b111) begin
        errors++;
        $display("FAIL midphase_period4 got=%b%b%b exp=111", tr_rise[r + 7][1], tr_fall[r + 9][1], tr_rise[r + 11][1]);
      end
    end
  endtask

  task automatic test_disable();
    int act;
    int hi;
    act = 0;
    hi = 0;
    for (int i = 0; i < 26; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL disable_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      tr_clk[i] = clk_o; tr_rise[i] = rise_o; tr_fall[i] = fall_o; tr_pend[i] = pending_o;
      div_we_i = '0; sync_i = 1'b0;
      if (i == 0) begin set_div(2, 3); div_we_i[2] = 1'b1; en_i[2] = 1'b1; end
      if (i == 5) en_i[2] = 1'b0;
      if (i == 14) en_i[2] = 1'b1;
      if (i == 16) en_i[2] = 1'b0;
    end
    for (int j = 5; j <= 8; j++) if (tr_clk[j][2]) hi++;
    for (int j = 10; j < 26; j++) if (tr_clk[j][2] | tr_rise[j][2] | tr_fall[j][2] | tr_pend[j][2]) act++;
    checks++;
    if (tr_rise[5][2] !== 1'b1 || hi != 4) begin
      errors++;
      $display("FAIL disable_high got rise=%b high=%0d exp rise=1 high=4", tr_rise[5][2], hi);
    end
    checks++;
    if ({tr_fall[9][2], tr_clk[9][2]} !== 2'b10) begin
      errors++;
      $display("FAIL disable_fall got=%b%b exp=10", tr_fall[9][2], tr_clk[9][2]);
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL disable_idle got=%0d active cycles exp=0", act);
    end
  endtask

  task automatic test_sync();
    int s;
    int r0;
    int r3;
    s = 5 + int'($urandom_range(0, 6));
    r0 = -1;
    r3 = -1;
    for (int i = 0; i < 24; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL sync_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      tr_clk[i] = clk_o; tr_rise[i] = rise_o; tr_fall[i] = fall_o; tr_pend[i] = pending_o;
      if (i > s + 1 && r0 < 0 && rise_o[0]) r0 = i;
      if (i > s + 1 && r3 < 0 && rise_o[3]) r3 = i;
      div_we_i = '0; sync_i = 1'b0;
      if (i == 0) begin
        set_div(0, 2); div_we_i[0] = 1'b1;
        set_div(3, 5); div_we_i[3] = 1'b1; en_i[3] = 1'b1;
      end
      if (i == s) sync_i = 1'b1;
    end
    checks++;
    if ({tr_clk[s + 1][0], tr_clk[s + 1][3]} !== 2'b00) begin
      errors++;
      $display("FAIL sync_low got=%b%b exp=00", tr_clk[s + 1][0], tr_clk[s + 1][3]);
    end
    checks++;
    if (r0 - (s + 1) != 3 || r3 - (s + 1) != 6) begin
      errors++;
      $display("FAIL sync_phase got ch0=%0d ch3=%0d exp ch0=3 ch3=6", r0 - (s + 1), r3 - (s + 1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL random_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      div_we_i = '0; sync_i = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          set_div(k, int'($urandom_range(0, 5)));
          div_we_i[k] = 1'b1;
        end
        if ($urandom_range(0, 19) == 0) en_i[k] = !en_i[k];
      end
      if ($urandom_range(0, 39) == 0) sync_i = 1'b1;
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 14; i++) begin
      cyc1();
      checks++;
      if ({clk_o, rise_o, fall_o, pending_o} !== {m_clk, m_rise, m_fall, m_pend}) begin
        errors++;
        $display("FAIL rst_mid_model obs=%0d got=%h exp=%h", i, {clk_o, rise_o, fall_o, pending_o}, {m_clk, m_rise, m_fall, m_pend});
      end
      tr_clk[i] = clk_o; tr_rise[i] = rise_o; tr_fall[i] = fall_o; tr_pend[i] = pending_o;
      div_we_i = '0; sync_i = 1'b0;
      if (i == 0) begin
        for (int k = 0; k < N_CH; k++) set_div(k, 3);
        div_we_i = '1; en_i = '1; sync_i = 1'b1;
      end
      if (i == 6) rst = 1'b1;
      if (i == 7) rst = 1'b0;
    end
    checks++;
    if ({tr_rise[5], tr_clk[6]} !== 8'hff) begin
      errors++;
      $display("FAIL rst_mid_high got=%h exp=ff", {tr_rise[5], tr_clk[6]});
    end
    checks++;
    if ({tr_clk[7], tr_rise[7], tr_fall[7], tr_pend[7]} !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_clear got=%h exp=0", {tr_clk[7], tr_rise[7], tr_fall[7], tr_pend[7]});
    end
    checks++;
    if ({tr_clk[8], tr_rise[9], tr_fall[10]} !== 12'h0ff) begin
      errors++;
      $display("FAIL rst_mid_divrst got=%h exp=0ff", {tr_clk[8], tr_rise[9], tr_fall[10]});
    end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_idle_write();
    test_midphase_write();
    test_disable();
    test_sync();
    test_random();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
